// File: rtl/dispatch_ctrl_pkg.sv
// rtl/dispatch_ctrl_pkg.sv - shared types and constants for the dispatch control unit
//
// Purpose : FSM state encoding and execution-queue index constants shared by
//           dispatch_ctrl and its bench.
// Ports   : none (package)
package dispatch_ctrl_pkg;

  typedef enum logic {
    S_RUN      = 1'b0,
    S_REDIRECT = 1'b1
  } state_t;

  localparam logic [1:0] EQ_INT  = 2'd0;
  localparam logic [1:0] EQ_LS   = 2'd1;
  localparam logic [1:0] EQ_MULT = 2'd2;
  localparam logic [1:0] EQ_DIV  = 2'd3;

endpackage

// File: rtl/br_fifo.sv
// rtl/br_fifo.sv - circular in-order target FIFO with push, pop, clear, count and head
//
// Purpose : holds targets of outstanding in-order items (branch targets here).
//           Clear wins over push/pop. Pop of an empty FIFO and push into a
//           full FIFO (without a simultaneous pop) are ignored.
// Ports   : clk, rst_n      clock, async active-low reset
//           i_push, i_data push strobe and data
//           i_pop          pop the head entry
//           i_clear        drop every entry
//           o_count        entries held
//           o_head         oldest entry (valid when o_count != 0)
module br_fifo #(
  parameter int DEPTH  = 2,
  parameter int W_DATA = 32,
  parameter int W_CNT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [W_DATA-1:0] i_data,
  input  logic              i_pop,
  input  logic              i_clear,
  output logic [W_CNT-1:0]  o_count,
  output logic [W_DATA-1:0] o_head
);

  localparam int W_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W_DATA-1:0] r_mem [DEPTH];
  logic [W_PTR-1:0]  r_wr_ptr;
  logic [W_PTR-1:0]  r_rd_ptr;
  logic [W_CNT-1:0]  r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [W_PTR-1:0] f_inc(input logic [W_PTR-1:0] p);
    if (p == W_PTR'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == W_CNT'(DEPTH));
  assign w_pop   = i_pop & ~w_empty;
  assign w_push  = i_push & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= f_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + W_CNT'(1);
        2'b01:   r_count <= r_count - W_CNT'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/dispatch_ctrl.sv
// rtl/dispatch_ctrl.sv - dispatch control with speculative multi-branch tracking
//
// Purpose : decides each cycle whether the IFQ head fires into an execution
//           queue, pops tags, tracks outstanding conditional branches and
//           issues registered IFQ redirects (jumps, taken branches + flush).
// Ports   : clk, reset                  clock, async active-low reset
//           dec_*                       decoded IFQ head instruction
//           equeue_ready / equeue_en    per-queue ready / one-hot enqueue
//           tagfifo_empty / tagfifo_ren tag availability / pop
//           rst_wen                     write allocated tag into RST
//           ifq_ren                     consume IFQ head
//           ifq_branch_valid/_addr      registered redirect
//           flush                       registered squash pulse
//           cdb_branch, cdb_branch_taken in-order branch resolution
//           br_count                    outstanding branches
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int N_EQ      = 4,
  parameter int W_EQIDX   = 2,
  parameter int BR_DEPTH  = 2,
  parameter int W_BRCNT   = 2,
  parameter bit MODE_SPEC = 1'b1,
  parameter int W_PC      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dec_valid,
  input  logic [W_EQIDX-1:0] dec_eqidx,
  input  logic               dec_req_equeue,
  input  logic               dec_req_tag,
  input  logic               dec_is_branch,
  input  logic               dec_is_jump,
  input  logic [W_PC-1:0]    dec_branch_addr,
  input  logic [W_PC-1:0]    dec_jump_addr,
  input  logic [N_EQ-1:0]    equeue_ready,
  output logic [N_EQ-1:0]    equeue_en,
  input  logic               tagfifo_empty,
  output logic               tagfifo_ren,
  output logic               rst_wen,
  output logic               ifq_ren,
  output logic               ifq_branch_valid,
  output logic [W_PC-1:0]    ifq_branch_addr,
  output logic               flush,
  input  logic               cdb_branch,
  input  logic               cdb_branch_taken,
  output logic [W_BRCNT-1:0] br_count
);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_redir_valid;
  logic              w_redir_valid_next;
  logic [W_PC-1:0]   r_redir_addr;
  logic [W_PC-1:0]   w_redir_addr_next;
  logic              r_flush;
  logic              w_flush_next;

  logic [W_BRCNT-1:0] w_br_count;
  logic [W_PC-1:0]    w_br_head;
  logic               w_br_busy;
  logic               w_taken_res;
  logic               w_br_ok;
  logic               w_stall_spec;
  logic               w_eq_ok;
  logic               w_tag_ok;
  logic               w_fire;

  assign w_br_busy   = (w_br_count != '0);
  assign w_taken_res = cdb_branch & cdb_branch_taken & w_br_busy;

  // Non-speculative mode behaves as depth 1: a branch may only fire into an
  // empty tracker, and nothing at all fires while one is outstanding.
  assign w_br_ok = ~dec_is_branch |
                   ((MODE_SPEC != 1'b0) ? (w_br_count < W_BRCNT'(BR_DEPTH)) : ~w_br_busy);
  assign w_stall_spec = (MODE_SPEC == 1'b0) & w_br_busy;

  assign w_eq_ok  = ~dec_req_equeue | equeue_ready[dec_eqidx];
  assign w_tag_ok = ~dec_req_tag | ~tagfifo_empty;

  // Gated by reset so every combinational strobe is quiet while held in reset.
  assign w_fire = reset & (r_state == S_RUN) & dec_valid & ~w_taken_res &
                  ~w_stall_spec & w_br_ok & w_eq_ok & w_tag_ok;

  always_comb begin
    equeue_en            = '0;
    equeue_en[dec_eqidx] = w_fire & dec_req_equeue;
  end

  assign ifq_ren     = w_fire;
  assign tagfifo_ren = w_fire & dec_req_tag;
  assign rst_wen     = w_fire & dec_req_tag;

  br_fifo #(
    .DEPTH  (BR_DEPTH),
    .W_DATA (W_PC),
    .W_CNT  (W_BRCNT)
  ) u_br_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_fire & dec_is_branch),
    .i_data  (dec_branch_addr),
    .i_pop   (cdb_branch),
    .i_clear (w_taken_res),
    .o_count (w_br_count),
    .o_head  (w_br_head)
  );

  // Taken resolution outranks a jump; w_fire already excludes taken cycles.
  // S_REDIRECT always falls back to S_RUN, so the redirect and flush strobes
  // are single-cycle pulses.
  always_comb begin
    w_state_next       = S_RUN;
    w_redir_valid_next = 1'b0;
    w_redir_addr_next  = r_redir_addr;
    w_flush_next       = 1'b0;
    if (w_taken_res) begin
      w_state_next       = S_REDIRECT;
      w_redir_valid_next = 1'b1;
      w_redir_addr_next  = w_br_head;
      w_flush_next       = 1'b1;
    end else if (w_fire && dec_is_jump) begin
      w_state_next       = S_REDIRECT;
      w_redir_valid_next = 1'b1;
      w_redir_addr_next  = dec_jump_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_RUN;
      r_redir_valid <= 1'b0;
      r_redir_addr  <= '0;
      r_flush       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_redir_valid <= w_redir_valid_next;
      r_redir_addr  <= w_redir_addr_next;
      r_flush       <= w_flush_next;
    end
  end

  assign ifq_branch_valid = r_redir_valid;
  assign ifq_branch_addr  = r_redir_addr;
  assign flush            = r_flush;
  assign br_count         = w_br_count;

endmodule
